// File: rtl/montgomery_wrap.sv
// Sequential modular multiplier: y = a*b mod m via two radix-2 Montgomery products.
// Optional busy output enabled by defining MONTGOMERY_WRAP_BUSY_EN.
module montgomery_wrap #(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  input  logic [10:0]      m_size,
  input  logic [NBITS-1:0] r_red,
  output logic [NBITS-1:0] y,
  output logic             done_irq_p
`ifdef MONTGOMERY_WRAP_BUSY_EN
  ,
  output logic             busy
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    FIX1,
    MUL2,
    FIX2
  } state_t;

  state_t state;

  logic [NBITS-1:0] ra;
  logic [NBITS-1:0] rb;
  logic [NBITS-1:0] rm;
  logic [NBITS-1:0] rr;
  logic [NBITS-1:0] p1;
  logic [10:0]      rn;
  logic [10:0]      cnt;
  logic [NBITS+1:0] s;

  logic [NBITS-1:0] xs;
  logic [NBITS-1:0] ys;
  logic             xbit;
  logic [NBITS+1:0] sum;
  logic [NBITS+1:0] odd_fix;
  logic [NBITS+1:0] step;
  logic [NBITS+1:0] fix;
  logic             last;
  logic             bad_size;

  // Second product multiplies P1 by R^2 mod m to leave the Montgomery domain
  always_comb begin
    xs       = (state == MUL2) ? p1 : ra;
    ys       = (state == MUL2) ? rr : rb;
    xbit     = 1'(xs >> cnt);
    sum      = s + {2'b00, (xbit ? ys : '0)};
    odd_fix  = sum[0] ? (sum + {2'b00, rm}) : sum;
    step     = odd_fix >> 1;
    fix      = (s >= {2'b00, rm}) ? (s - {2'b00, rm}) : s;
    last     = (cnt == (rn - 11'd1));
    bad_size = (m_size == 11'd0) || (m_size > 11'(NBITS));
  end

`ifdef MONTGOMERY_WRAP_BUSY_EN
  assign busy = (state != IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      y          <= '0;
      done_irq_p <= 1'b0;
      ra         <= '0;
      rb         <= '0;
      rm         <= '0;
      rr         <= '0;
      p1         <= '0;
      rn         <= '0;
      cnt        <= '0;
      s          <= '0;
    end else begin
      done_irq_p <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable_p) begin
            ra  <= a;
            rb  <= b;
            rm  <= m;
            rr  <= r_red;
            rn  <= m_size;
            s   <= '0;
            cnt <= '0;
            // Illegal size skips straight to the final cycle with S = 0
            state <= bad_size ? FIX2 : MUL1;
          end
        end
        MUL1: begin
          s   <= step;
          cnt <= cnt + 11'd1;
          if (last) begin
            cnt   <= '0;
            state <= FIX1;
          end
        end
        FIX1: begin
          p1    <= fix[NBITS-1:0];
          s     <= '0;
          cnt   <= '0;
          state <= MUL2;
        end
        MUL2: begin
          s   <= step;
          cnt <= cnt + 11'd1;
          if (last) begin
            cnt   <= '0;
            state <= FIX2;
          end
        end
        FIX2: begin
          s          <= fix;
          y          <= fix[NBITS-1:0];
          done_irq_p <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_wrap.sv
// Directed and randomized checks of montgomery_wrap against a.b mod m.
// Busy checks apply when MONTGOMERY_WRAP_BUSY_EN is defined.
module tb_montgomery_wrap;

  localparam int NBITS = 256;

  logic             clk;
  logic             rst_n;
  logic             enable_p;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic [NBITS-1:0] m;
  logic [10:0]      m_size;
  logic [NBITS-1:0] r_red;
  logic [NBITS-1:0] y;
  logic             done_irq_p;
`ifdef MONTGOMERY_WRAP_BUSY_EN
  logic             busy;
`endif

  int total;
  int bad;

  montgomery_wrap #(.NBITS(NBITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_p   (enable_p),
    .a          (a),
    .b          (b),
    .m          (m),
    .m_size     (m_size),
    .r_red      (r_red),
    .y          (y),
    .done_irq_p (done_irq_p)
`ifdef MONTGOMERY_WRAP_BUSY_EN
    ,
    .busy       (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NBITS-1:0] obs,
                       input logic [NBITS-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned rsq(input longint unsigned mm,
                                          input int n);
    longint unsigned r;
    r = 1 % mm;
    for (int i = 0; i < 2 * n; i++) r = (r * 2) % mm;
    return r;
  endfunction

  function automatic int bitlen(input longint unsigned v);
    int n;
    n = 0;
    while (v != 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  // Start one operation, measure latency to done and check y.
  task automatic run_op(input string tag, input longint unsigned va,
                        input longint unsigned vb, input longint unsigned vm,
                        input int n, input longint unsigned vr,
                        input longint unsigned exp_y, input int exp_lat,
                        input bit disturb);
    int cyc;
    bit seen;
    a        = NBITS'(va);
    b        = NBITS'(vb);
    m        = NBITS'(vm);
    m_size   = 11'(n);
    r_red    = NBITS'(vr);
    enable_p = 1'b1;
    @(posedge clk);
    #1;
    enable_p = 1'b0;
`ifdef MONTGOMERY_WRAP_BUSY_EN
    check({tag, "_busy_rise"}, NBITS'(busy), NBITS'(1));
`endif
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      if (disturb && cyc == 3) begin
        a        = NBITS'(3);
        b        = NBITS'(4);
        m        = NBITS'(11);
        m_size   = 11'd4;
        enable_p = 1'b1;
      end else begin
        enable_p = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done_irq_p) seen = 1'b1;
    end
    enable_p = 1'b0;
    check({tag, "_seen"}, NBITS'(seen), NBITS'(1));
    check({tag, "_lat"}, NBITS'(cyc), NBITS'(exp_lat));
    check({tag, "_y"}, y, NBITS'(exp_y));
`ifdef MONTGOMERY_WRAP_BUSY_EN
    check({tag, "_busy_fall"}, NBITS'(busy), NBITS'(0));
`endif
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, NBITS'(done_irq_p), NBITS'(0));
    check({tag, "_hold"}, y, NBITS'(exp_y));
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done_irq_p) hits++;
    end
    check(tag, NBITS'(hits), NBITS'(0));
  endtask

  initial begin
    longint unsigned rm;
    longint unsigned ra;
    longint unsigned rb;
    int rn;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    enable_p = 1'b0;
    a        = '0;
    b        = '0;
    m        = '0;
    m_size   = '0;
    r_red    = '0;
    #2;
    check("rst_async_y", y, '0);
    check("rst_async_done", NBITS'(done_irq_p), '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", y, '0);
    check("rst_done", NBITS'(done_irq_p), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("basic", 7, 5, 13, 4, 9, 9, 10, 1'b0);
    run_op("typical", 57, 12, 97, 7, 88, 5, 16, 1'b1);
    quiet("typical_no_extra", 25);
    run_op("a_zero", 0, 5, 13, 4, 9, 0, 10, 1'b0);
    run_op("a12_b12", 12, 12, 13, 4, 9, 1, 10, 1'b0);
    run_op("size0", 7, 5, 13, 0, 9, 0, 1, 1'b0);
    run_op("basic2", 7, 5, 13, 4, 9, 9, 10, 1'b0);
    run_op("size300", 7, 5, 13, 300, 9, 0, 1, 1'b0);

    // Abort mid-operation
    a        = NBITS'(57);
    b        = NBITS'(12);
    m        = NBITS'(97);
    m_size   = 11'd7;
    r_red    = NBITS'(88);
    enable_p = 1'b1;
    @(posedge clk);
    #1;
    enable_p = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_y", y, '0);
    check("abort_done", NBITS'(done_irq_p), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet("abort_no_done", 20);
    check("abort_y_after", y, '0);
    run_op("restart", 57, 12, 97, 7, 88, 5, 16, 1'b0);

    for (int k = 0; k < 8; k++) begin
      rm = longint'($urandom_range(65535, 3)) | 64'd1;
      rn = bitlen(rm);
      ra = longint'($urandom) % rm;
      rb = longint'($urandom) % rm;
      run_op($sformatf("rand%0d", k), ra, rb, rm, rn, rsq(rm, rn),
             (ra * rb) % rm, 2 * rn + 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
